serial_frame_rx: RTL and testbench
==================================

# serial_frame_rx

Byte-to-frame decoder placed directly downstream of `serial_async_rx`. It consumes received bytes (level-type word-finished flag plus parallel word) and assembles frames of the form SYNC, LENGTH, PAYLOAD[LENGTH], CHECKSUM. It checks each frame's length and checksum, stores the payload in an internal buffer, and holds it for a consumer until acknowledged.

## Interface
- `BITS`, 8, word width; must match the receiver.
- `MAX_LEN`, 16, maximum payload bytes; buffer depth.
- `SYNC_WORD`, 8'hAA, frame start marker.
- `TIMEOUT_CYCLES`, 1024, maximum in_clk cycles allowed between bytes inside a frame.
- `in_clk`  in  1  main clock; the only clock.
- `in_rst`  in  1  reset; synchronous, active-high.
- `in_enable`  in  1  block enable; when low, everything is frozen.
- `in_word`  in  BITS  received byte (receiver `out_parallel`).
- `in_word_finished`  in  1  receiver word-finished level; a rising edge marks a new byte.
- `in_ack`  in  1  consumer has read the frame.
- `in_rd_addr`  in  $clog2(MAX_LEN)  payload read address.
- `out_rd_data`  out  BITS  combinational payload byte at `in_rd_addr`; 0 if `in_rd_addr >= out_frame_len`.
- `out_frame_len`  out  $clog2(MAX_LEN+1)  payload length of the held frame.
- `out_frame_valid`  out  1  a checked frame is held.
- `out_busy`  out  1  inside a frame (Length/Payload/Checksum).
- `out_err_checksum`, `out_err_length`, `out_err_timeout`, `out_err_overrun`  out  1 each  single-cycle error pulses.

## Operation
- **Strobe generation.**
  - Register `last_finished` (set to 1 during reset).
  - strobe = `in_word_finished & ~last_finished & in_enable`.
  - A level held high across reset release therefore produces no strobe.
- **States:** Idle, Length, Payload, Checksum, Done.
  - Idle: on a strobe with `in_word == SYNC_WORD`, go to Length; all other bytes are ignored silently.
  - Length:
    - On a strobe, if `in_word > MAX_LEN`: pulse `out_err_length`, go to Idle.
    - Otherwise latch len, sum = in_word, idx = 0.
    - Go to Checksum if len == 0, else go to Payload.
  - Payload: on each strobe, buf[idx] <= in_word, sum += in_word, idx++. After the byte where idx == len-1, go to Checksum.
  - Checksum: on a strobe:
    - If `in_word == sum`: `out_frame_len` <= len, go to Done.
    - Otherwise pulse `out_err_checksum` and go to Idle; `out_frame_len` is unchanged.
  - Done:
    - `out_frame_valid` = 1.
    - Any strobe: byte dropped, `out_err_overrun` pulsed.
    - `in_ack`: go to Idle.
    - `in_ack` and a strobe in the same cycle: go to Idle, byte dropped, overrun pulsed.
- **Checksum rule:** sum = (LENGTH + all payload bytes) mod 2^BITS; the SYNC byte is excluded.
- **Timeout.**
  - A counter runs in Length/Payload/Checksum and clears on every strobe and on state entry.
  - When `TIMEOUT_CYCLES` consecutive cycles pass without a strobe: pulse `out_err_timeout`, go to Idle.
  - If a strobe arrives in the same cycle the count would expire, the strobe wins; no timeout.
- **`in_enable` low:** state, counter, buffer and outputs hold; error pulses are 0.
- **Payload buffer.**
  - A new frame overwrites the buffer in place.
  - `out_rd_data` is defined only while `out_frame_valid` = 1.
- `out_busy` = 1 in Length, Payload and Checksum.

## Timing
- **Reset values:** state Idle; `out_frame_valid` 0; `out_frame_len` 0; `out_busy` 0; all error pulses 0; `out_rd_data` 0. Buffer contents are not reset.
- **Byte capture:** strobe is combinational in cycle k, and the byte is captured at the rising edge that ends cycle k.
- **Frame completion:** when the checksum byte's strobe is in cycle k, `out_frame_valid` and `out_frame_len` are visible in cycle k+1.
- **Error pulses:** registered, high exactly one cycle (cycle k+1 after the offending strobe or timeout).
- **Ack:** `in_ack` sampled in cycle k → `out_frame_valid` is 0 in cycle k+1. The next SYNC is accepted from cycle k+1.
- **Reset mid-frame:** asserting `in_rst` at any edge returns the block to the reset values on that edge; a partial frame is discarded with no error pulse.
- **Throughput:** one byte per strobe; no back-pressure toward the receiver.

## Test plan
1. **Good frame with leading garbage.** Bytes 00, 55, AA, 03, 11, 22, 33, 69 → `out_frame_valid`=1 with `out_frame_len`=3; `out_rd_data` at addresses 0/1/2 = 11/22/33; address 3 → 00; no error pulses.
2. **Checksum wrap and mismatch.** Bytes AA, 02, FF, 02, 03 → valid, len 2. After ack, bytes AA, 02, FF, 02, 04 → one `out_err_checksum` pulse, `out_frame_valid` stays 0, state Idle.
3. **Length bounds.** Bytes AA, 11 (17 > MAX_LEN) → one `out_err_length` pulse. Bytes AA, 00, 00 → valid with `out_frame_len`=0. Bytes AA, 10, then 16 payload bytes, then correct sum → valid with len 16.
4. **Timeout.** Bytes AA, 02, 11, then silence → `out_err_timeout` pulses exactly `TIMEOUT_CYCLES` cycles after the 11 strobe. A following frame AA, 01, 05, 06 is accepted.
5. **Overrun and ack.** While Done with frame {11,22,33}, send byte 77 → one `out_err_overrun` pulse, buffer still 11/22/33. Then `in_ack` together with a strobe → valid is 0 next cycle and an overrun pulse is seen. Then a SYNC is accepted.
6. **Reset and enable.** Assert `in_rst` after AA, 03, 11 while `in_word_finished` is held high across the reset → all reset values, no spurious byte. With `in_enable`=0, edges on `in_word_finished` are ignored and no timeout occurs.

Source files
------------

// File: rtl/serial_frame_rx.sv
// serial_frame_rx
//   Byte-to-frame decoder fed by serial_async_rx. Assembles frames of the form
//   SYNC, LENGTH, PAYLOAD[LENGTH], CHECKSUM, where
//   CHECKSUM = (LENGTH + sum of payload) mod 2^BITS.
//   A checked payload is held in an internal buffer until the consumer acks it.
//
// Ports
//   in_clk, in_rst      clock, synchronous active-high reset
//   in_enable           low freezes all state; error pulses read 0
//   in_word             received byte
//   in_word_finished    receiver level flag; its rising edge marks a new byte
//   in_ack              consumer has read the held frame
//   in_rd_addr          payload read address
//   out_rd_data         payload byte at in_rd_addr, 0 beyond out_frame_len
//   out_frame_len       payload length of the held frame
//   out_frame_valid     a checked frame is held
//   out_busy            inside a frame (Length/Payload/Checksum)
//   out_err_*           single-cycle error pulses
module serial_frame_rx #(
  parameter int unsigned     BITS           = 8,
  parameter int unsigned     MAX_LEN        = 16,
  parameter logic [BITS-1:0] SYNC_WORD      = 8'hAA,
  parameter int unsigned     TIMEOUT_CYCLES = 1024
) (
  input  logic                         in_clk,
  input  logic                         in_rst,
  input  logic                         in_enable,
  input  logic [BITS-1:0]              in_word,
  input  logic                         in_word_finished,
  input  logic                         in_ack,
  input  logic [$clog2(MAX_LEN)-1:0]   in_rd_addr,
  output logic [BITS-1:0]              out_rd_data,
  output logic [$clog2(MAX_LEN+1)-1:0] out_frame_len,
  output logic                         out_frame_valid,
  output logic                         out_busy,
  output logic                         out_err_checksum,
  output logic                         out_err_length,
  output logic                         out_err_timeout,
  output logic                         out_err_overrun
);

  localparam int unsigned AW = $clog2(MAX_LEN);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LENGTH,
    S_PAYLOAD,
    S_CHECKSUM,
    S_DONE
  } state_t;

  state_t          state, state_next;
  logic            last_finished;
  logic            strobe;
  logic            expire;
  logic [CW-1:0]   cnt;
  logic [LW-1:0]   len, len_next;
  logic [LW-1:0]   frame_len_next;
  logic [BITS-1:0] sum, sum_next;
  logic [AW-1:0]   idx, idx_next;
  logic            wr_en;
  logic            err_cks_next, err_len_next, err_to_next, err_ovr_next;
  logic [BITS-1:0] mem [MAX_LEN];

  assign strobe          = in_word_finished & ~last_finished & in_enable;
  assign out_busy        = (state == S_LENGTH) || (state == S_PAYLOAD) || (state == S_CHECKSUM);
  assign out_frame_valid = (state == S_DONE);
  // A strobe in the expiring cycle wins over the timeout.
  assign expire          = out_busy && !strobe && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge in_clk) begin
    if (in_rst) state <= S_IDLE;
    else if (in_enable) state <= state_next;
  end

  always_comb begin
    state_next     = state;
    len_next       = len;
    sum_next       = sum;
    idx_next       = idx;
    frame_len_next = out_frame_len;
    wr_en          = 1'b0;
    err_cks_next   = 1'b0;
    err_len_next   = 1'b0;
    err_to_next    = 1'b0;
    err_ovr_next   = 1'b0;
    case (state)
      S_IDLE: begin
        if (strobe && in_word == SYNC_WORD) state_next = S_LENGTH;
      end
      S_LENGTH: begin
        if (strobe) begin
          if (in_word > BITS'(MAX_LEN)) begin
            err_len_next = 1'b1;
            state_next   = S_IDLE;
          end else begin
            len_next   = LW'(in_word);
            sum_next   = in_word;
            idx_next   = '0;
            state_next = (in_word == '0) ? S_CHECKSUM : S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (strobe) begin
          wr_en    = 1'b1;
          sum_next = sum + in_word;
          idx_next = idx + AW'(1);
          if (LW'(idx) == len - LW'(1)) state_next = S_CHECKSUM;
        end
      end
      S_CHECKSUM: begin
        if (strobe) begin
          if (in_word == sum) begin
            frame_len_next = len;
            state_next     = S_DONE;
          end else begin
            err_cks_next = 1'b1;
            state_next   = S_IDLE;
          end
        end
      end
      S_DONE: begin
        if (strobe) err_ovr_next = 1'b1;
        if (in_ack) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (expire) begin
      err_to_next = 1'b1;
      state_next  = S_IDLE;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      last_finished    <= 1'b1;
      cnt              <= '0;
      len              <= '0;
      sum              <= '0;
      idx              <= '0;
      out_frame_len    <= '0;
      out_err_checksum <= 1'b0;
      out_err_length   <= 1'b0;
      out_err_timeout  <= 1'b0;
      out_err_overrun  <= 1'b0;
    end else begin
      // The edge detector keeps tracking while disabled so that edges seen
      // during that time are discarded instead of firing on re-enable.
      last_finished <= in_word_finished;
      if (in_enable) begin
        cnt              <= (strobe || !out_busy || expire) ? '0 : cnt + CW'(1);
        len              <= len_next;
        sum              <= sum_next;
        idx              <= idx_next;
        out_frame_len    <= frame_len_next;
        out_err_checksum <= err_cks_next;
        out_err_length   <= err_len_next;
        out_err_timeout  <= err_to_next;
        out_err_overrun  <= err_ovr_next;
      end else begin
        out_err_checksum <= 1'b0;
        out_err_length   <= 1'b0;
        out_err_timeout  <= 1'b0;
        out_err_overrun  <= 1'b0;
      end
    end
  end

  // Payload buffer: not reset, overwritten in place by each new frame.
  always_ff @(posedge in_clk) begin
    if (wr_en) mem[idx] <= in_word;
  end

  always_comb begin
    out_rd_data = '0;
    if (LW'(in_rd_addr) < out_frame_len) out_rd_data = mem[in_rd_addr];
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed self-checking bench for serial_frame_rx.
module tb_serial_frame_rx;
  localparam int unsigned TO = 1024;

  logic       in_clk = 1'b0;
  logic       in_rst = 1'b1;
  logic       in_enable = 1'b1;
  logic [7:0] in_word = 8'h00;
  logic       in_word_finished = 1'b0;
  logic       in_ack = 1'b0;
  logic [3:0] in_rd_addr = 4'd0;
  logic [7:0] out_rd_data;
  logic [4:0] out_frame_len;
  logic       out_frame_valid, out_busy;
  logic       out_err_checksum, out_err_length, out_err_timeout, out_err_overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int c_cks = 0, c_len = 0, c_to = 0, c_ovr = 0;

  always #5 in_clk = ~in_clk;

  serial_frame_rx #(
    .BITS(8), .MAX_LEN(16), .SYNC_WORD(8'hAA), .TIMEOUT_CYCLES(TO)
  ) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_enable(in_enable),
    .in_word(in_word), .in_word_finished(in_word_finished), .in_ack(in_ack),
    .in_rd_addr(in_rd_addr), .out_rd_data(out_rd_data),
    .out_frame_len(out_frame_len), .out_frame_valid(out_frame_valid),
    .out_busy(out_busy), .out_err_checksum(out_err_checksum),
    .out_err_length(out_err_length), .out_err_timeout(out_err_timeout),
    .out_err_overrun(out_err_overrun)
  );

  // Error pulse tally: each visible high cycle counted once.
  always @(posedge in_clk) begin
    if (out_err_checksum) c_cks++;
    if (out_err_length)   c_len++;
    if (out_err_timeout)  c_to++;
    if (out_err_overrun)  c_ovr++;
  end

  // Called at a negedge; returns at the negedge right after the capture edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge in_clk);
    in_word = b;
    in_word_finished = 1'b1;
    @(negedge in_clk);
    in_word_finished = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge in_clk);
    in_ack = 1'b1;
    @(negedge in_clk);
    in_ack = 1'b0;
  endtask

  task automatic test_reset();
    in_rst = 1'b1;
    repeat (3) @(negedge in_clk);
    n_cmp++; if (out_frame_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_frame_valid); end
    n_cmp++; if (out_frame_len !== 5'd0) begin n_bad++; $display("FAIL reset_len: got %0d want 0", out_frame_len); end
    n_cmp++; if (out_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", out_busy); end
    n_cmp++; if (out_rd_data !== 8'h00) begin n_bad++; $display("FAIL reset_rd: got %h want 00", out_rd_data); end
    n_cmp++; if ({out_err_checksum, out_err_length, out_err_timeout, out_err_overrun} !== 4'b0)
      begin n_bad++; $display("FAIL reset_errs: got %b want 0000", {out_err_checksum, out_err_length, out_err_timeout, out_err_overrun}); end
    in_rst = 1'b0;
    repeat (2) @(negedge in_clk);
  endtask

  task automatic test_good_frame();
    logic [7:0] seq [8] = '{8'h00, 8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h00};
    int e0;
    e0 = c_cks + c_len + c_to + c_ovr;
    for (int i = 0; i < 8; i++) send_byte(seq[i]);
    n_cmp++; if (out_frame_valid !== 1'b1) begin n_bad++; $display("FAIL good_valid: got %b want 1", out_frame_valid); end
    n_cmp++; if (out_frame_len !== 5'd3) begin n_bad++; $display("FAIL good_len: got %0d want 3", out_frame_len); end
    for (int a = 0; a < 4; a++) begin
      in_rd_addr = 4'(a);
      #1;
      n_cmp++; if (out_rd_data !== exp[a]) begin n_bad++; $display("FAIL good_rd[%0d]: got %h want %h", a, out_rd_data, exp[a]); end
    end
    @(negedge in_clk);
    n_cmp++; if (c_cks + c_len + c_to + c_ovr !== e0) begin n_bad++; $display("FAIL good_noerr: got %0d pulses want 0", c_cks + c_len + c_to + c_ovr - e0); end
    do_ack();
    n_cmp++; if (out_frame_valid !== 1'b0) begin n_bad++; $display("FAIL good_ack: got %b want 0", out_frame_valid); end
  endtask

  task automatic test_checksum();
    logic [7:0] ok [5]  = '{8'hAA, 8'h02, 8'hFF, 8'h02, 8'h03};
    logic [7:0] bad [5] = '{8'hAA, 8'h02, 8'hFF, 8'h02, 8'h04};
    int e0;
    for (int i = 0; i < 5; i++) send_byte(ok[i]);
    n_cmp++; if (out_frame_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_valid: got %b want 1", out_frame_valid); end
    n_cmp++; if (out_frame_len !== 5'd2) begin n_bad++; $display("FAIL wrap_len: got %0d want 2", out_frame_len); end
    in_rd_addr = 4'd0; #1;
    n_cmp++; if (out_rd_data !== 8'hFF) begin n_bad++; $display("FAIL wrap_rd0: got %h want ff", out_rd_data); end
    do_ack();
    e0 = c_cks;
    for (int i = 0; i < 5; i++) send_byte(bad[i]);
    n_cmp++; if (out_err_checksum !== 1'b1) begin n_bad++; $display("FAIL cks_pulse: got %b want 1", out_err_checksum); end
    n_cmp++; if (out_frame_valid !== 1'b0) begin n_bad++; $display("FAIL cks_valid: got %b want 0", out_frame_valid); end
    n_cmp++; if (out_busy !== 1'b0) begin n_bad++; $display("FAIL cks_idle: got busy %b want 0", out_busy); end
    n_cmp++; if (out_frame_len !== 5'd2) begin n_bad++; $display("FAIL cks_len_kept: got %0d want 2", out_frame_len); end
    @(negedge in_clk);
    n_cmp++; if (out_err_checksum !== 1'b0) begin n_bad++; $display("FAIL cks_single: got %b want 0", out_err_checksum); end
    n_cmp++; if (c_cks - e0 !== 1) begin n_bad++; $display("FAIL cks_count: got %0d want 1", c_cks - e0); end
  endtask

  task automatic test_length();
    int e0;
    e0 = c_len;
    send_byte(8'hAA); send_byte(8'h11);
    n_cmp++; if (out_err_length !== 1'b1) begin n_bad++; $display("FAIL len_pulse: got %b want 1", out_err_length); end
    n_cmp++; if (out_busy !== 1'b0) begin n_bad++; $display("FAIL len_idle: got busy %b want 0", out_busy); end
    send_byte(8'hAA); send_byte(8'h00); send_byte(8'h00);
    n_cmp++; if (out_frame_valid !== 1'b1) begin n_bad++; $display("FAIL len0_valid: got %b want 1", out_frame_valid); end
    n_cmp++; if (out_frame_len !== 5'd0) begin n_bad++; $display("FAIL len0_len: got %0d want 0", out_frame_len); end
    in_rd_addr = 4'd0; #1;
    n_cmp++; if (out_rd_data !== 8'h00) begin n_bad++; $display("FAIL len0_rd: got %h want 00", out_rd_data); end
    do_ack();
    send_byte(8'hAA); send_byte(8'h10);
    for (int i = 1; i <= 16; i++) send_byte(8'(i));
    send_byte(8'h98);  // 0x10 + (1+..+16) = 0x98
    n_cmp++; if (out_frame_valid !== 1'b1) begin n_bad++; $display("FAIL len16_valid: got %b want 1", out_frame_valid); end
    n_cmp++; if (out_frame_len !== 5'd16) begin n_bad++; $display("FAIL len16_len: got %0d want 16", out_frame_len); end
    in_rd_addr = 4'd15; #1;
    n_cmp++; if (out_rd_data !== 8'h10) begin n_bad++; $display("FAIL len16_rd15: got %h want 10", out_rd_data); end
    in_rd_addr = 4'd0; #1;
    n_cmp++; if (out_rd_data !== 8'h01) begin n_bad++; $display("FAIL len16_rd0: got %h want 01", out_rd_data); end
    do_ack();
    n_cmp++; if (c_len - e0 !== 1) begin n_bad++; $display("FAIL len_count: got %0d want 1", c_len - e0); end
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h11);
    // Now just after the capture edge of 0x11; pulse expected after TO more edges.
    for (int j = 1; j < TO; j++) begin
      @(negedge in_clk);
      if (out_err_timeout) early++;
    end
    n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL to_early: got %0d pulses want 0", early); end
    n_cmp++; if (out_busy !== 1'b1) begin n_bad++; $display("FAIL to_busy_before: got %b want 1", out_busy); end
    @(negedge in_clk);
    n_cmp++; if (out_err_timeout !== 1'b1) begin n_bad++; $display("FAIL to_pulse: got %b want 1", out_err_timeout); end
    n_cmp++; if (out_busy !== 1'b0) begin n_bad++; $display("FAIL to_idle: got busy %b want 0", out_busy); end
    @(negedge in_clk);
    n_cmp++; if (out_err_timeout !== 1'b0) begin n_bad++; $display("FAIL to_single: got %b want 0", out_err_timeout); end
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h05); send_byte(8'h06);
    n_cmp++; if (out_frame_valid !== 1'b1) begin n_bad++; $display("FAIL to_next_valid: got %b want 1", out_frame_valid); end
    in_rd_addr = 4'd0; #1;
    n_cmp++; if (out_rd_data !== 8'h05) begin n_bad++; $display("FAIL to_next_rd: got %h want 05", out_rd_data); end
    do_ack();
  endtask

  task automatic test_overrun();
    logic [7:0] seq [6] = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
    int e0;
    for (int i = 0; i < 6; i++) send_byte(seq[i]);
    e0 = c_ovr;
    send_byte(8'h77);
    n_cmp++; if (out_err_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_pulse: got %b want 1", out_err_overrun); end
    n_cmp++; if (out_frame_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_valid: got %b want 1", out_frame_valid); end
    for (int a = 0; a < 3; a++) begin
      in_rd_addr = 4'(a);
      #1;
      n_cmp++; if (out_rd_data !== exp[a]) begin n_bad++; $display("FAIL ovr_rd[%0d]: got %h want %h", a, out_rd_data, exp[a]); end
    end
    @(negedge in_clk);
    in_ack = 1'b1; in_word = 8'h88; in_word_finished = 1'b1;
    @(negedge in_clk);
    in_ack = 1'b0; in_word_finished = 1'b0;
    n_cmp++; if (out_frame_valid !== 1'b0) begin n_bad++; $display("FAIL ackovr_valid: got %b want 0", out_frame_valid); end
    n_cmp++; if (out_err_overrun !== 1'b1) begin n_bad++; $display("FAIL ackovr_pulse: got %b want 1", out_err_overrun); end
    send_byte(8'hAA);
    n_cmp++; if (out_busy !== 1'b1) begin n_bad++; $display("FAIL ackovr_sync: got busy %b want 1", out_busy); end
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h06);
    n_cmp++; if (out_frame_len !== 5'd1) begin n_bad++; $display("FAIL ackovr_len: got %0d want 1", out_frame_len); end
    do_ack();
    n_cmp++; if (c_ovr - e0 !== 2) begin n_bad++; $display("FAIL ovr_count: got %0d want 2", c_ovr - e0); end
  endtask

  task automatic test_reset_enable();
    int e0;
    e0 = c_cks + c_len + c_to + c_ovr;
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11);
    @(negedge in_clk);
    in_word = 8'hAA; in_word_finished = 1'b1; in_rst = 1'b1;
    @(negedge in_clk);
    in_rst = 1'b0;
    n_cmp++; if (out_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", out_busy); end
    n_cmp++; if (out_frame_len !== 5'd0) begin n_bad++; $display("FAIL rst_len: got %0d want 0", out_frame_len); end
    n_cmp++; if (out_frame_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", out_frame_valid); end
    repeat (3) @(negedge in_clk);
    n_cmp++; if (out_busy !== 1'b0) begin n_bad++; $display("FAIL rst_spurious: got busy %b want 0", out_busy); end
    in_word_finished = 1'b0;
    @(negedge in_clk);
    in_enable = 1'b0;
    send_byte(8'hAA); send_byte(8'h01);
    n_cmp++; if (out_busy !== 1'b0) begin n_bad++; $display("FAIL dis_ignored: got busy %b want 0", out_busy); end
    in_enable = 1'b1;
    send_byte(8'hAA);
    in_enable = 1'b0;
    repeat (TO + 100) @(negedge in_clk);
    send_byte(8'h55);
    n_cmp++; if (out_busy !== 1'b1) begin n_bad++; $display("FAIL dis_frozen: got busy %b want 1", out_busy); end
    @(negedge in_clk);
    in_enable = 1'b1;
    send_byte(8'h01); send_byte(8'h07); send_byte(8'h08);
    n_cmp++; if (out_frame_valid !== 1'b1) begin n_bad++; $display("FAIL dis_resume_valid: got %b want 1", out_frame_valid); end
    in_rd_addr = 4'd0; #1;
    n_cmp++; if (out_rd_data !== 8'h07) begin n_bad++; $display("FAIL dis_resume_rd: got %h want 07", out_rd_data); end
    do_ack();
    @(negedge in_clk);
    n_cmp++; if (c_cks + c_len + c_to + c_ovr !== e0) begin n_bad++; $display("FAIL rst_dis_noerr: got %0d pulses want 0", c_cks + c_len + c_to + c_ovr - e0); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_checksum();
    test_length();
    test_timeout();
    test_overrun();
    test_reset_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
